// File: rtl/multu_pkg.sv
// Shared definitions for the sequential unsigned (optionally signed) multiplier:
// FSM state encoding, default operand width and iteration-counter width.
package multu_pkg;

   localparam int WIDTH_DEF = 32;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   // Wide enough to hold WIDTH itself so the iteration count never wraps.
   localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multu_seq.sv
// Iterative shift-add multiplier: one partial-product step per BUSY cycle, product
// registered on entry to DONE. Define MULTU_SIGNED_EN to add the Signed port.
module multu_seq
   import multu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Start,
   input  logic [WIDTH-1:0]   SrcA,
   input  logic [WIDTH-1:0]   SrcB,
`ifdef MULTU_SIGNED_EN
   input  logic               Signed,
`endif
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] MultuAns
);

   localparam int CW = (WIDTH == WIDTH_DEF) ? CNT_W_DEF : cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [WIDTH-1:0]   mcand_reg, mplr_reg;
   logic [2*WIDTH-1:0] acc_reg, ans_reg;
   logic [2*WIDTH-1:0] acc_next, product;
   logic [WIDTH:0]     sum;
   logic               accept, last;
`ifdef MULTU_SIGNED_EN
   logic               neg_reg;
`endif

   assign accept = Start && (state_reg != BUSY);
   assign last   = (state_reg == BUSY) && (cnt_reg == LAST_CNT);

   // Carry out of the upper-half add is kept and shifted back into the MSB.
   always_comb begin
      sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (mplr_reg[0] ? {1'b0, mcand_reg} : '0);
      acc_next = (2*WIDTH)'({sum, acc_reg[WIDTH-1:0]} >> 1);
`ifdef MULTU_SIGNED_EN
      product  = neg_reg ? -acc_next : acc_next;
`else
      product  = acc_next;
`endif
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (Start) state_next = BUSY;
         BUSY:    if (last)  state_next = DONE;
         DONE:    state_next = Start ? BUSY : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_reg <= '0;
         mplr_reg  <= '0;
         acc_reg   <= '0;
         ans_reg   <= '0;
         cnt_reg   <= '0;
`ifdef MULTU_SIGNED_EN
         neg_reg   <= 1'b0;
`endif
      end else if (accept) begin
`ifdef MULTU_SIGNED_EN
         // Work on magnitudes; the sign is reapplied to the full-width result.
         mcand_reg <= (Signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
         mplr_reg  <= (Signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;
         neg_reg   <= Signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
`else
         mcand_reg <= SrcA;
         mplr_reg  <= SrcB;
`endif
         acc_reg   <= '0;
         cnt_reg   <= '0;
      end else if (state_reg == BUSY) begin
         acc_reg  <= acc_next;
         mplr_reg <= mplr_reg >> 1;
         cnt_reg  <= cnt_reg + 1'b1;
         if (last) ans_reg <= product;
      end
   end

   assign Busy     = (state_reg == BUSY);
   assign Done     = (state_reg == DONE);
   assign MultuAns = ans_reg;

endmodule

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq: an edge-counting product model is compared every
// cycle, and hand-computed literals pin latency, carry path, restart and reset cases.
module tb_multu_seq;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           Start = 1'b0;
   logic [W-1:0]   SrcA = '0;
   logic [W-1:0]   SrcB = '0;
   logic           sgn = 1'b0;
   logic           Busy, Done;
   logic [2*W-1:0] MultuAns;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multu_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .Start    (Start),
      .SrcA     (SrcA),
      .SrcB     (SrcB),
`ifdef MULTU_SIGNED_EN
      .Signed   (sgn),
`endif
      .Busy     (Busy),
      .Done     (Done),
      .MultuAns (MultuAns)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      longint sa, sb;
      logic [63:0] ua, ub;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`ifdef MULTU_SIGNED_EN
      if (s) return 64'(sa * sb);
`else
      if (s) return ua * ub;
`endif
      return ua * ub;
   endfunction

   // Model: an op accepted at rising edge k is busy after edges k..k+W-1 and
   // shows its product with Done after edge k+W; Start at edges k+1..k+W is ignored.
   int          edge_n = 0;
   int          m_acc = 0;
   bit          m_active = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   logic [63:0] m_ans = '0;
   logic [63:0] m_prod = '0;

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_active = 1'b0;
         m_busy   = 1'b0;
         m_done   = 1'b0;
         m_ans    = '0;
      end else begin
         edge_n++;
         if (m_active && edge_n == m_acc + W) m_ans = m_prod;
         if (Start && !(m_active && edge_n > m_acc && edge_n <= m_acc + W)) begin
            m_active = 1'b1;
            m_acc    = edge_n;
            m_prod   = ref_prod(SrcA, SrcB, sgn);
         end
         m_busy = m_active && edge_n >= m_acc && edge_n < m_acc + W;
         m_done = m_active && edge_n == m_acc + W;
      end
   end

   initial forever begin
      @(negedge clk);
      check("cyc_busy", {63'b0, Busy}, {63'b0, m_busy});
      check("cyc_done", {63'b0, Done}, {63'b0, m_done});
      check("cyc_ans", MultuAns, m_ans);
   end

   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      Start = 1'b1;
      SrcA  = a;
      SrcB  = b;
      sgn   = s;
      @(negedge clk);
      Start = 1'b0;
   endtask

   // Counts falling edges after the accepting edge until Done is seen.
   task automatic wait_done(input int n0, output int n, output int busy_n);
      n      = n0;
      busy_n = 0;
      while (!Done && n < n0 + 100) begin
         if (Busy) busy_n++;
         @(negedge clk);
         n++;
      end
      check("done_timeout", {63'b0, Done}, 64'd1);
   endtask

   initial begin
      int n, b, pulses;

      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'b0, Busy}, 64'd0);
      check("rst_done", {63'b0, Done}, 64'd0);
      check("rst_ans", MultuAns, 64'd0);
      reset = 1'b1;

      launch(32'd3, 32'd5, 1'b0);
      wait_done(1, n, b);
      check("t1_latency", n, 33);
      check("t1_busy_cycles", b, 32);
      check("t1_ans", MultuAns, 64'h0000_0000_0000_000F);
      $display("op 3*5 latency=%0d busy=%0d ans=0x%016h", n, b, MultuAns);

      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_done(1, n, b);
      check("t2_latency", n, 33);
      check("t2_ans", MultuAns, 64'hFFFF_FFFE_0000_0001);
      $display("op ffffffff*ffffffff latency=%0d ans=0x%016h", n, MultuAns);

      launch(32'd1000, 32'd1000, 1'b0);
      repeat (9) @(negedge clk);
      Start = 1'b1;
      SrcA  = 32'd7;
      @(negedge clk);
      Start = 1'b0;
      wait_done(11, n, b);
      check("t3_latency", n, 33);
      check("t3_ans", MultuAns, 64'h0000_0000_000F_4240);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (Done) pulses++;
      end
      check("t3_extra_done", pulses, 0);
      check("t3_ans_held", MultuAns, 64'h0000_0000_000F_4240);
      $display("op 1000*1000 with ignored restart latency=%0d ans=0x%016h", n, MultuAns);

      launch(32'd6, 32'd7, 1'b0);
      wait_done(1, n, b);
      check("t4a_ans", MultuAns, 64'd42);
      Start = 1'b1;
      SrcA  = 32'd2;
      SrcB  = 32'd4;
      @(negedge clk);
      Start = 1'b0;
      check("t4_no_bubble", {63'b0, Busy}, 64'd1);
      check("t4_held", MultuAns, 64'd42);
      wait_done(1, n, b);
      check("t4_latency", n, 33);
      check("t4_ans", MultuAns, 64'd8);
      $display("op 2*4 back-to-back latency=%0d ans=0x%016h", n, MultuAns);

      launch(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
      repeat (15) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t5_rst_busy", {63'b0, Busy}, 64'd0);
      check("t5_rst_done", {63'b0, Done}, 64'd0);
      check("t5_rst_ans", MultuAns, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (Done) pulses++;
      end
      check("t5_no_done", pulses, 0);
      launch(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
      wait_done(1, n, b);
      check("t5_latency", n, 33);
      check("t5_ans", MultuAns, 64'h0000_0000_FFFE_0001);
      $display("op ffff*ffff after reset latency=%0d ans=0x%016h", n, MultuAns);

`ifdef MULTU_SIGNED_EN
      launch(32'hFFFF_FFFE, 32'd3, 1'b1);
      wait_done(1, n, b);
      check("t6_signed_latency", n, 33);
      check("t6_signed_ans", MultuAns, 64'hFFFF_FFFF_FFFF_FFFA);
      $display("op signed -2*3 latency=%0d ans=0x%016h", n, MultuAns);
`endif
      launch(32'hFFFF_FFFE, 32'd3, 1'b0);
      wait_done(1, n, b);
      check("t6_unsigned_ans", MultuAns, 64'h0000_0002_FFFF_FFFA);
      $display("op unsigned fffffffe*3 latency=%0d ans=0x%016h", n, MultuAns);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
